// File: rtl/sdram_rw_arbiter_pkg.sv
// rtl/sdram_rw_arbiter_pkg.sv - shared state/grant encodings and default widths
package sdram_rw_arbiter_pkg;

    localparam int ADDR_W_DEF      = 24;
    localparam int BURST_W_DEF     = 10;
    localparam int RFIFO_DEPTH_DEF = 1024;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_REQ   = 3'd1,
        S_WR_BURST = 3'd2,
        S_RD_REQ   = 3'd3,
        S_RD_BURST = 3'd4,
        S_UPDATE   = 3'd5
    } state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// rtl/sdram_rw_arbiter_if.sv - request/ack/address bundle between arbiter and SDRAM controller
interface sdram_rw_arbiter_if
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int BURST_W = BURST_W_DEF
);
    logic               sdram_init_done;
    logic               sdram_wr_ack;
    logic               sdram_rd_ack;
    logic               sdram_wr_req;
    logic               sdram_rd_req;
    logic [ADDR_W-1:0]  sdram_wr_addr;
    logic [ADDR_W-1:0]  sdram_rd_addr;
    logic [BURST_W-1:0] sdram_wr_burst;
    logic [BURST_W-1:0] sdram_rd_burst;

    modport master (
        input  sdram_init_done, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
               sdram_wr_burst, sdram_rd_burst
    );

    modport slave (
        output sdram_init_done, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
               sdram_wr_burst, sdram_rd_burst
    );
endinterface

// File: rtl/sdram_addr_ptr.sv
// rtl/sdram_addr_ptr.sv - windowed address pointer with ping-pong bank bit and load handling
module sdram_addr_ptr
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int   ADDR_W      = ADDR_W_DEF,
    parameter int   BURST_W     = BURST_W_DEF,
    parameter int   PINGPONG_EN = 1,
    parameter logic LOAD_BANK   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-2:0]  min_addr,
    input  logic [ADDR_W-2:0]  max_addr,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               load,
    input  logic               apply,
    input  logic               update,
    input  logic               wrap_bank,
    output logic [ADDR_W-2:0]  ptr,
    output logic               bank,
    output logic               pending,
    output logic               wrap_pulse
);
    // With ping-pong disabled the bank bit never leaves 0, including after reset and loads.
    localparam logic HOME_BANK = (PINGPONG_EN != 0) ? LOAD_BANK : 1'b0;

    logic [ADDR_W-1:0] next_addr;
    logic              wrap;

    assign next_addr = {1'b0, ptr} + ADDR_W'(burst_len);
    assign wrap      = (next_addr >= {1'b0, max_addr});

    // Pointer/bank/pending state; a load seen with a wrap suppresses the frame pulse
    // because the pending load will overwrite the wrapped pointer in the next IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            bank       <= HOME_BANK;
            pending    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (apply && pending) begin
                ptr     <= min_addr;
                bank    <= HOME_BANK;
                pending <= load;
            end else begin
                if (load) begin
                    pending <= 1'b1;
                end
                if (update) begin
                    if (wrap) begin
                        ptr        <= min_addr;
                        wrap_pulse <= !(load || pending);
                        if (PINGPONG_EN != 0) begin
                            bank <= wrap_bank;
                        end
                    end else begin
                        ptr <= next_addr[ADDR_W-2:0];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/sdram_rw_arbiter.sv
// rtl/sdram_rw_arbiter.sv - round-robin write/read burst scheduler for the SDRAM controller
module sdram_rw_arbiter
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int BURST_W     = BURST_W_DEF,
    parameter int RFIFO_DEPTH = RFIFO_DEPTH_DEF,
    parameter int PINGPONG_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BURST_W-1:0] wfifo_rdusedw,
    input  logic [BURST_W-1:0] rfifo_wrusedw,
    input  logic [ADDR_W-2:0]  wr_min_addr,
    input  logic [ADDR_W-2:0]  wr_max_addr,
    input  logic [BURST_W-1:0] wr_burst_len,
    input  logic [ADDR_W-2:0]  rd_min_addr,
    input  logic [ADDR_W-2:0]  rd_max_addr,
    input  logic [BURST_W-1:0] rd_burst_len,
    input  logic               rd_valid,
    input  logic               wr_load,
    input  logic               rd_load,
    sdram_rw_arbiter_if.master ctl,
    output logic               frame_wr_done,
    output logic               busy
);
    localparam logic [BURST_W:0] RD_DEPTH = (BURST_W+1)'(RFIFO_DEPTH);

    state_t            state, state_d;
    grant_t            last_grant;
    logic              wr_go, rd_go;
    logic              wr_elig, rd_elig;
    logic [BURST_W:0]  rd_fill_sum;
    logic [ADDR_W-2:0] wr_ptr, rd_ptr;
    logic              wr_bank, rd_bank;
    logic              wr_pending, rd_pending;

    assign rd_fill_sum = {1'b0, rfifo_wrusedw} + {1'b0, rd_burst_len};
    assign wr_elig     = ctl.sdram_init_done & (wfifo_rdusedw >= wr_burst_len);
    assign rd_elig     = ctl.sdram_init_done & rd_valid & (rd_fill_sum <= RD_DEPTH);
    assign busy        = (state != S_IDLE);

    sdram_addr_ptr #(
        .ADDR_W(ADDR_W), .BURST_W(BURST_W), .PINGPONG_EN(PINGPONG_EN), .LOAD_BANK(1'b0)
    ) u_wr_ptr (
        .clk(clk), .rst(rst), .min_addr(wr_min_addr), .max_addr(wr_max_addr),
        .burst_len(wr_burst_len), .load(wr_load), .apply(state == S_IDLE),
        .update((state == S_UPDATE) && (last_grant == GRANT_WR)), .wrap_bank(~wr_bank),
        .ptr(wr_ptr), .bank(wr_bank), .pending(wr_pending), .wrap_pulse(frame_wr_done)
    );

    // The read side lands on the bank the writer is not filling.
    sdram_addr_ptr #(
        .ADDR_W(ADDR_W), .BURST_W(BURST_W), .PINGPONG_EN(PINGPONG_EN), .LOAD_BANK(1'b1)
    ) u_rd_ptr (
        .clk(clk), .rst(rst), .min_addr(rd_min_addr), .max_addr(rd_max_addr),
        .burst_len(rd_burst_len), .load(rd_load), .apply(state == S_IDLE),
        .update((state == S_UPDATE) && (last_grant == GRANT_RD)), .wrap_bank(~wr_bank),
        .ptr(rd_ptr), .bank(rd_bank), .pending(rd_pending), .wrap_pulse()
    );

    // Next-state and grant decision; pending loads block grants for the cycle they apply.
    always_comb begin
        state_d = state;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!(wr_pending || rd_pending)) begin
                    if (wr_elig && rd_elig) begin
                        wr_go = (last_grant == GRANT_RD);
                        rd_go = (last_grant == GRANT_WR);
                    end else begin
                        wr_go = wr_elig;
                        rd_go = rd_elig;
                    end
                end
                if (wr_go) state_d = S_WR_REQ;
                if (rd_go) state_d = S_RD_REQ;
            end
            S_WR_REQ:   if (ctl.sdram_wr_ack)  state_d = S_WR_BURST;
            S_WR_BURST: if (!ctl.sdram_wr_ack) state_d = S_UPDATE;
            S_RD_REQ:   if (ctl.sdram_rd_ack)  state_d = S_RD_BURST;
            S_RD_BURST: if (!ctl.sdram_rd_ack) state_d = S_UPDATE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and controller-facing registers; last_grant also names the grant in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            last_grant         <= GRANT_RD;
            ctl.sdram_wr_req   <= 1'b0;
            ctl.sdram_rd_req   <= 1'b0;
            ctl.sdram_wr_addr  <= '0;
            ctl.sdram_rd_addr  <= '0;
            ctl.sdram_wr_burst <= '0;
            ctl.sdram_rd_burst <= '0;
        end else begin
            state            <= state_d;
            ctl.sdram_wr_req <= (state_d == S_WR_REQ);
            ctl.sdram_rd_req <= (state_d == S_RD_REQ);
            if (wr_go) begin
                last_grant         <= GRANT_WR;
                ctl.sdram_wr_burst <= wr_burst_len;
                ctl.sdram_wr_addr  <= {wr_bank, wr_ptr};
            end
            if (rd_go) begin
                last_grant         <= GRANT_RD;
                ctl.sdram_rd_burst <= rd_burst_len;
                ctl.sdram_rd_addr  <= {rd_bank, rd_ptr};
            end
        end
    end
endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// tb/tb_sdram_rw_arbiter.sv - self-checking bench with grant scoreboard and controller model
module tb_sdram_rw_arbiter;
    logic        clk, rst;
    logic [9:0]  wfifo_rdusedw, rfifo_wrusedw, wr_burst_len, rd_burst_len;
    logic [22:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
    logic        rd_valid, wr_load, rd_load, frame_wr_done, busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pops = 0;
    int          fwd_count = 0;
    bit          ctl_en = 1'b1;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;
    logic [63:0] exp_q[$];

    sdram_rw_arbiter_if #(.ADDR_W(24), .BURST_W(10)) bus ();

    sdram_rw_arbiter #(.ADDR_W(24), .BURST_W(10), .RFIFO_DEPTH(1024), .PINGPONG_EN(1)) dut (
        .clk(clk), .rst(rst),
        .wfifo_rdusedw(wfifo_rdusedw), .rfifo_wrusedw(rfifo_wrusedw),
        .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr), .wr_burst_len(wr_burst_len),
        .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr), .rd_burst_len(rd_burst_len),
        .rd_valid(rd_valid), .wr_load(wr_load), .rd_load(rd_load),
        .ctl(bus), .frame_wr_done(frame_wr_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic kind, input logic [23:0] addr, input logic [9:0] len);
        return {29'd0, kind, addr, len};
    endfunction

    task automatic sb_pop(input logic [63:0] obs);
        pops++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL sb_grant: observed %0h expected none", obs);
        end else begin
            check("sb_grant", obs, exp_q.pop_front());
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.sdram_wr_req;
            1:       return bus.sdram_rd_req;
            2:       return !busy;
            default: return bus.sdram_wr_ack;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        int n = 0;
        while (!sig(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(sig(which)), 64'd1);
    endtask

    task automatic run_write(input logic [23:0] addr, input string tag);
        exp_q.push_back(mk(1'b0, addr, 10'd256));
        wfifo_rdusedw = 10'd256;
        wait_for(0, 3, tag);
        wfifo_rdusedw = 10'd0;
        wait_for(2, 600, "wr_done");
        repeat (2) @(negedge clk);
    endtask

    task automatic run_read(input logic [23:0] addr, input string tag);
        exp_q.push_back(mk(1'b1, addr, 10'd256));
        rfifo_wrusedw = 10'd0;
        rd_valid = 1'b1;
        wait_for(1, 3, tag);
        rd_valid = 1'b0;
        wait_for(2, 600, "rd_done");
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every rising request is one grant to compare.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sdram_wr_req && !prev_wr) sb_pop(mk(1'b0, bus.sdram_wr_addr, bus.sdram_wr_burst));
            if (bus.sdram_rd_req && !prev_rd) sb_pop(mk(1'b1, bus.sdram_rd_addr, bus.sdram_rd_burst));
            if (frame_wr_done) fwd_count++;
        end
        prev_wr = bus.sdram_wr_req;
        prev_rd = bus.sdram_rd_req;
    end

    // Controller model: ack for burst-length cycles, req must be low the cycle after ack rises.
    initial begin
        int len;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ctl_en && bus.sdram_wr_req) begin
                len = int'(bus.sdram_wr_burst);
                bus.sdram_wr_ack = 1'b1;
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if (i == 0) check("wr_req_drop", 64'(bus.sdram_wr_req), 64'd0);
                end
                bus.sdram_wr_ack = 1'b0;
            end else if (!rst && ctl_en && bus.sdram_rd_req) begin
                len = int'(bus.sdram_rd_burst);
                bus.sdram_rd_ack = 1'b1;
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if (i == 0) check("rd_req_drop", 64'(bus.sdram_rd_req), 64'd0);
                end
                bus.sdram_rd_ack = 1'b0;
            end
        end
    end

    initial begin
        int seen;
        int base;
        int n;
        rst = 1'b1;
        wfifo_rdusedw = 10'd512;
        rfifo_wrusedw = 10'd0;
        wr_burst_len = 10'd256;
        rd_burst_len = 10'd256;
        wr_min_addr = 23'd0;
        wr_max_addr = 23'd512;
        rd_min_addr = 23'd0;
        rd_max_addr = 23'd512;
        rd_valid = 1'b0;
        wr_load = 1'b0;
        rd_load = 1'b0;
        bus.sdram_init_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({bus.sdram_wr_req, bus.sdram_rd_req, frame_wr_done, busy}), 64'd0);
        check("rst_addr", 64'({bus.sdram_wr_addr, bus.sdram_rd_addr}), 64'd0);
        check("rst_burst", 64'({bus.sdram_wr_burst, bus.sdram_rd_burst}), 64'd0);
        rst = 1'b0;

        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.sdram_wr_req) seen++;
        end
        check("init_gate", 64'(seen), 64'd0);
        exp_q.push_back(mk(1'b0, 24'h000000, 10'd256));
        bus.sdram_init_done = 1'b1;
        wait_for(0, 2, "init_latency");
        wfifo_rdusedw = 10'd0;
        check("wr_burst_latched", 64'(bus.sdram_wr_burst), 64'd256);
        wait_for(2, 600, "wr_done");
        repeat (2) @(negedge clk);
        check("fwd_after_1", 64'(fwd_count), 64'd0);

        wfifo_rdusedw = 10'd255;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.sdram_wr_req) seen++;
        end
        check("wfifo_short", 64'(seen), 64'd0);
        run_write(24'h000100, "wr2_req");
        check("fwd_after_2", 64'(fwd_count), 64'd1);
        run_write(24'h800000, "wr3_req");
        check("fwd_after_3", 64'(fwd_count), 64'd1);

        rd_valid = 1'b1;
        rfifo_wrusedw = 10'd900;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.sdram_rd_req) seen++;
        end
        check("rd_backpressure", 64'(seen), 64'd0);
        exp_q.push_back(mk(1'b1, 24'h800000, 10'd256));
        rfifo_wrusedw = 10'd768;
        wait_for(1, 3, "rd_boundary");
        rfifo_wrusedw = 10'd900;
        check("rd_burst_latched", 64'(bus.sdram_rd_burst), 64'd256);
        wait_for(2, 600, "rd_done");
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);

        exp_q.push_back(mk(1'b0, 24'h800100, 10'd256));
        exp_q.push_back(mk(1'b1, 24'h800100, 10'd256));
        exp_q.push_back(mk(1'b0, 24'h000000, 10'd256));
        exp_q.push_back(mk(1'b1, 24'h800000, 10'd256));
        exp_q.push_back(mk(1'b0, 24'h000100, 10'd256));
        exp_q.push_back(mk(1'b1, 24'h800100, 10'd256));
        exp_q.push_back(mk(1'b0, 24'h800000, 10'd256));
        exp_q.push_back(mk(1'b1, 24'h000000, 10'd256));
        base = pops;
        wfifo_rdusedw = 10'd512;
        rfifo_wrusedw = 10'd0;
        rd_valid = 1'b1;
        n = 0;
        while (pops < base + 8 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("rr_8_grants", 64'(pops - base), 64'd8);
        wfifo_rdusedw = 10'd0;
        rd_valid = 1'b0;
        wait_for(2, 600, "rr_done");
        repeat (2) @(negedge clk);
        check("fwd_after_rr", 64'(fwd_count), 64'd3);

        exp_q.push_back(mk(1'b0, 24'h800100, 10'd256));
        wfifo_rdusedw = 10'd256;
        wait_for(0, 3, "load_wr_req");
        wfifo_rdusedw = 10'd0;
        wait_for(3, 5, "load_wr_ack");
        repeat (10) @(negedge clk);
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        check("load_addr_hold", 64'(bus.sdram_wr_addr), 64'h800100);
        wait_for(2, 600, "load_wr_done");
        repeat (2) @(negedge clk);
        check("load_no_fwd", 64'(fwd_count), 64'd3);
        run_write(24'h000000, "after_load_req");

        ctl_en = 1'b0;
        exp_q.push_back(mk(1'b1, 24'h000100, 10'd256));
        rfifo_wrusedw = 10'd0;
        rd_valid = 1'b1;
        wait_for(1, 3, "rst_rd_req");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({bus.sdram_wr_req, bus.sdram_rd_req, frame_wr_done, busy}), 64'd0);
        check("rst_mid_addr", 64'({bus.sdram_wr_addr, bus.sdram_rd_addr}), 64'd0);
        check("rst_mid_burst", 64'({bus.sdram_wr_burst, bus.sdram_rd_burst}), 64'd0);
        rd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ctl_en = 1'b1;
        run_write(24'h000000, "post_rst_wr");
        run_read(24'h800000, "post_rst_rd");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
